// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the iteration-counter width helper.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    // Counter must hold values 0..w inclusive (w iterations or w leading zeros).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_lzc.sv
// Combinational leading-zero counter for the dividend. Used only by the
// early-termination variant to skip the dividend's leading zero bits.
module seq_divider_lzc
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic [WIDTH-1:0] value_i,
    output logic [CNT_W-1:0] lz_o,
    output logic             all_zero_o
);

    // Scan upward; the highest set bit is the last to overwrite the count.
    always_comb begin
        lz_o = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value_i[i]) begin
                lz_o = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

    assign all_zero_o = ~|value_i;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring unsigned divider, one quotient bit per clock.
// CONST_TIME=1 always iterates WIDTH times; CONST_TIME=0 skips the
// dividend's leading zeros, so latency depends on the data.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit CONST_TIME = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero,
    output logic             busy,
    output logic             finish
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] d_q;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] p_q;      // partial remainder
    logic [WIDTH-1:0] div_q;    // latched divisor
    logic [WIDTH-1:0] a_q;      // latched dividend, reported as rem on /0
    logic             dbz_q;    // latched divisor==0 flag
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_out_q;
    logic             busy_q;
    logic             finish_q;

    logic [CNT_W-1:0] lz;
    logic             all_zero;

    // The leading-zero counter exists only in the early-termination variant.
    generate
        if (!CONST_TIME) begin : g_lzc
            seq_divider_lzc #(.WIDTH(WIDTH)) u_lzc (
                .value_i    (in1),
                .lz_o       (lz),
                .all_zero_o (all_zero)
            );
        end else begin : g_no_lzc
            assign lz       = '0;
            assign all_zero = 1'b0;
        end
    endgenerate

    // One restoring step: shift the next dividend bit into the remainder,
    // subtract the divisor if it fits, shift the outcome into the quotient.
    logic [WIDTH:0]   r_w;
    logic             ge_w;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] d_d;

    assign r_w  = {p_q, d_q[WIDTH-1]};
    assign ge_w = (r_w >= {1'b0, div_q});
    assign p_d  = ge_w ? WIDTH'(r_w - {1'b0, div_q}) : r_w[WIDTH-1:0];
    assign d_d  = {d_q[WIDTH-2:0], ge_w};

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            d_q       <= '0;
            p_q       <= '0;
            div_q     <= '0;
            a_q       <= '0;
            dbz_q     <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_out_q <= 1'b0;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        div_q  <= in2;
                        a_q    <= in1;
                        dbz_q  <= (in2 == '0);
                        p_q    <= '0;
                        d_q    <= in1 << lz;
                        cnt_q  <= CNT_W'(WIDTH) - lz;
                        if (all_zero) begin
                            // Zero dividend in the leaky mode: no iterations needed.
                            state_q   <= S_DONE;
                            finish_q  <= 1'b1;
                            quot_q    <= (in2 == '0) ? '1 : '0;
                            rem_q     <= '0;
                            dbz_out_q <= (in2 == '0);
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    p_q   <= p_d;
                    d_q   <= d_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q   <= S_DONE;
                        finish_q  <= 1'b1;
                        quot_q    <= dbz_q ? '1  : d_d;
                        rem_q     <= dbz_q ? a_q : p_d;
                        dbz_out_q <= dbz_q;
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    finish_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    finish_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_out_q;
    assign busy        = busy_q;
    assign finish      = finish_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: one constant-time and one early-termination
// instance share clock, reset and operands; each has its own start.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_c, start_e;
    logic [7:0] in1, in2;

    logic [7:0] quot_c, rem_c, quot_e, rem_e;
    logic       dbz_c, busy_c, fin_c, dbz_e, busy_e, fin_e;

    int nvec = 0;
    int nerr = 0;
    bit sel_e = 1'b0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(8), .CONST_TIME(1'b1)) u_ct (
        .clk(clk), .rst_n(rst_n), .start(start_c), .in1(in1), .in2(in2),
        .quot(quot_c), .rem(rem_c), .div_by_zero(dbz_c), .busy(busy_c), .finish(fin_c)
    );

    seq_divider #(.WIDTH(8), .CONST_TIME(1'b0)) u_et (
        .clk(clk), .rst_n(rst_n), .start(start_e), .in1(in1), .in2(in2),
        .quot(quot_e), .rem(rem_e), .div_by_zero(dbz_e), .busy(busy_e), .finish(fin_e)
    );

    wire [7:0] quot_s = sel_e ? quot_e : quot_c;
    wire [7:0] rem_s  = sel_e ? rem_e  : rem_c;
    wire       dbz_s  = sel_e ? dbz_e  : dbz_c;
    wire       busy_s = sel_e ? busy_e : busy_c;
    wire       fin_s  = sel_e ? fin_e  : fin_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One division: pulse start, scramble operands, measure latency, check result.
    task automatic run_op(input bit et, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input bit ed, input int elat);
        int lat;
        sel_e = et;
        @(negedge clk);
        in1 = a;
        in2 = b;
        if (et) start_e = 1'b1; else start_c = 1'b1;
        @(posedge clk);
        #1;
        start_c = 1'b0;
        start_e = 1'b0;
        in1 = 8'hA5;
        in2 = 8'h00;
        chk("busy_after_accept", {31'b0, busy_s}, 32'd1);
        lat = 1;
        while (!fin_s && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("op et=%0d %0d/%0d -> quot=%0d rem=%0d dbz=%0d latency=%0d",
                 et, a, b, quot_s, rem_s, dbz_s, lat);
        chk("latency", lat, elat);
        chk("quot", {24'b0, quot_s}, {24'b0, eq});
        chk("rem", {24'b0, rem_s}, {24'b0, er});
        chk("div_by_zero", {31'b0, dbz_s}, {31'b0, ed});
        chk("busy_in_finish", {31'b0, busy_s}, 32'd1);
        @(posedge clk);
        #1;
        chk("finish_one_cycle", {31'b0, fin_s}, 32'd0);
        chk("busy_drops", {31'b0, busy_s}, 32'd0);
        chk("quot_held", {24'b0, quot_s}, {24'b0, eq});
    endtask

    initial begin
        int nfin;
        int first_lat;
        rst_n   = 1'b0;
        start_c = 1'b0;
        start_e = 1'b0;
        in1     = 8'd0;
        in2     = 8'd0;
        @(posedge clk);
        #1;
        chk("rst_quot_c", {24'b0, quot_c}, 32'd0);
        chk("rst_rem_c", {24'b0, rem_c}, 32'd0);
        chk("rst_flags_c", {29'b0, dbz_c, busy_c, fin_c}, 32'd0);
        chk("rst_flags_e", {29'b0, dbz_e, busy_e, fin_e}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Constant-time unit.
        run_op(1'b0, 8'd57,  8'd12, 8'd4,   8'd9,  1'b0, 9);
        run_op(1'b0, 8'd255, 8'd1,  8'd255, 8'd0,  1'b0, 9);
        run_op(1'b0, 8'd12,  8'd57, 8'd0,   8'd12, 1'b0, 9);
        run_op(1'b0, 8'd57,  8'd0,  8'd255, 8'd57, 1'b1, 9);
        run_op(1'b0, 8'd57,  8'd12, 8'd4,   8'd9,  1'b0, 9);

        // Early-termination unit.
        run_op(1'b1, 8'd3,   8'd1,  8'd3,   8'd0,  1'b0, 3);
        run_op(1'b1, 8'd0,   8'd5,  8'd0,   8'd0,  1'b0, 1);
        run_op(1'b1, 8'd200, 8'd7,  8'd28,  8'd4,  1'b0, 9);
        run_op(1'b1, 8'd57,  8'd0,  8'd255, 8'd57, 1'b1, 7);

        // start while busy is ignored; single finish pulse.
        sel_e = 1'b0;
        @(negedge clk);
        in1 = 8'd57;
        in2 = 8'd12;
        start_c = 1'b1;
        @(posedge clk);
        #1;
        start_c = 1'b0;
        nfin = 0;
        first_lat = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) begin
                in1 = 8'd100;
                in2 = 8'd3;
                start_c = 1'b1;
            end else begin
                start_c = 1'b0;
            end
            if (fin_c) begin
                nfin++;
                if (first_lat == 0) first_lat = c;
            end
            @(posedge clk);
            #1;
        end
        $display("busy-start: finish pulses=%0d first latency=%0d quot=%0d rem=%0d",
                 nfin, first_lat, quot_c, rem_c);
        chk("ignored_start_pulses", nfin, 32'd1);
        chk("ignored_start_latency", first_lat, 32'd9);
        chk("ignored_start_quot", {24'b0, quot_c}, 32'd4);
        chk("ignored_start_rem", {24'b0, rem_c}, 32'd9);
        chk("ignored_start_idle", {31'b0, busy_c}, 32'd0);

        // Back-to-back: start in the cycle right after finish.
        run_op(1'b0, 8'd57,  8'd12, 8'd4,   8'd9,  1'b0, 9);
        run_op(1'b0, 8'd100, 8'd3,  8'd33,  8'd1,  1'b0, 9);

        // Asynchronous reset in the middle of a calculation.
        @(negedge clk);
        in1 = 8'd57;
        in2 = 8'd12;
        start_c = 1'b1;
        @(posedge clk);
        #1;
        start_c = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
        end
        #3;
        rst_n = 1'b0;
        #1;
        $display("mid-calc reset: quot=%0d rem=%0d busy=%0d finish=%0d",
                 quot_c, rem_c, busy_c, fin_c);
        chk("midrst_quot", {24'b0, quot_c}, 32'd0);
        chk("midrst_rem", {24'b0, rem_c}, 32'd0);
        chk("midrst_flags", {29'b0, dbz_c, busy_c, fin_c}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 8'd57,  8'd12, 8'd4,   8'd9,  1'b0, 9);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
